instr_issue_sequencer: RTL and testbench

//  Program-driven instruction feeder for the pipelined ARM core. Holds a short

---
 rtl/instr_issue_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_instr_issue_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_sequencer.sv
// Program-driven instruction feeder for the pipelined ARM core: holds a short
// program, issues it with automatic NOP bubbles, supports single-step and drain.
module instr_issue_sequencer #(
  parameter int          DEPTH       = 16,
  parameter int          ADDR_W      = $clog2(DEPTH),
  parameter int          NOP_GAP     = 4,
  parameter int          HAZARD_MODE = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              abort,
  output logic [31:0]       Instruction,
  output logic              instr_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issued_count,
  output logic [15:0]       bubble_count
);

  localparam int CNT_W = (NOP_GAP > 1) ? $clog2(NOP_GAP) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(NOP_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT_STEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   pc, pc_nx, pc_inc, len_r, len_nx;
  logic              step_r, step_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [31:0]       instr_nx;
  logic              valid_nx, busy_nx, done_nx;
  logic [15:0]       issued_nx, bubble_nx;

  logic [31:0]       prog_buf [DEPTH];
  logic [31:0]       cur_word;

  logic [NOP_GAP-1:0] sb_valid;
  logic [3:0]         sb_rd [NOP_GAP];
  logic               sb_shift, sb_clear, sb_in_valid;
  logic [3:0]         sb_in_rd;

  logic               cur_writes, use_rn, use_rm, use_rd, hazard;

  // The buffer is only writable between runs so a running program stays stable.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      prog_buf[wr_addr] <= wr_data;
    end
  end

  assign cur_word = prog_buf[pc[ADDR_W-1:0]];
  assign pc_inc   = pc + 1'b1;

  // Register-use decode: data-processing and single data transfer only.
  always_comb begin
    cur_writes = 1'b0;
    use_rn     = 1'b0;
    use_rm     = 1'b0;
    use_rd     = 1'b0;
    case (cur_word[27:26])
      2'b00: begin
        cur_writes = (cur_word[24:23] != 2'b10);
        use_rn     = 1'b1;
        use_rm     = !cur_word[25];
      end
      2'b01: begin
        cur_writes = cur_word[20];
        use_rn     = 1'b1;
        use_rd     = !cur_word[20];
      end
      default: ;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NOP_GAP; i++) begin
      if (sb_valid[i]) begin
        if ((use_rn && sb_rd[i] == cur_word[19:16]) ||
            (use_rm && sb_rd[i] == cur_word[3:0])   ||
            (use_rd && sb_rd[i] == cur_word[15:12])) begin
          hazard = 1'b1;
        end
      end
    end
    if (HAZARD_MODE == 0) begin
      hazard = 1'b0;
    end
  end

  // Entry i holds the destination issued i+1 cycles ago, still in flight.
  always_ff @(posedge clk) begin
    if (reset || sb_clear) begin
      sb_valid <= '0;
    end else if (sb_shift) begin
      for (int i = NOP_GAP - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
      end
      sb_valid[0] <= sb_in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (sb_shift) begin
      for (int i = NOP_GAP - 1; i > 0; i--) begin
        sb_rd[i] <= sb_rd[i-1];
      end
      sb_rd[0] <= sb_in_rd;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    len_nx      = len_r;
    step_nx     = step_r;
    cnt_nx      = cnt;
    instr_nx    = NOP_WORD;
    valid_nx    = 1'b0;
    busy_nx     = busy;
    done_nx     = 1'b0;
    issued_nx   = issued_count;
    bubble_nx   = bubble_count;
    sb_shift    = 1'b0;
    sb_clear    = 1'b0;
    sb_in_valid = 1'b0;
    sb_in_rd    = cur_word[15:12];

    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          len_nx    = prog_len;
          step_nx   = step_mode;
          pc_nx     = '0;
          cnt_nx    = '0;
          issued_nx = '0;
          bubble_nx = '0;
          busy_nx   = 1'b1;
          sb_clear  = 1'b1;
          state_nx  = (prog_len == '0) ? S_DONE : S_ISSUE;
        end
      end

      S_ISSUE: begin
        sb_shift = 1'b1;
        if (pc >= len_r) begin
          bubble_nx = bubble_count + 16'd1;
          cnt_nx    = '0;
          state_nx  = S_DRAIN;
        end else if (hazard) begin
          bubble_nx = bubble_count + 16'd1;
        end else begin
          instr_nx    = cur_word;
          valid_nx    = 1'b1;
          pc_nx       = pc_inc;
          issued_nx   = issued_count + 16'd1;
          sb_in_valid = (HAZARD_MODE != 0) && cur_writes;
          cnt_nx      = '0;
          // The last word's trailing bubbles double as the drain.
          if (pc_inc == len_r) begin
            state_nx = S_DRAIN;
          end else if (HAZARD_MODE == 0) begin
            state_nx = S_GAP;
          end else if (step_r) begin
            state_nx = S_WAIT_STEP;
          end
        end
      end

      S_GAP: begin
        sb_shift  = 1'b1;
        bubble_nx = bubble_count + 16'd1;
        if (cnt == GAP_LAST) begin
          state_nx = step_r ? S_WAIT_STEP : S_ISSUE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_WAIT_STEP: begin
        sb_shift  = 1'b1;
        bubble_nx = bubble_count + 16'd1;
        if (step) begin
          state_nx = S_ISSUE;
        end
      end

      S_DRAIN: begin
        sb_shift  = 1'b1;
        bubble_nx = bubble_count + 16'd1;
        if (cnt == GAP_LAST) begin
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_DONE: begin
        sb_shift = 1'b1;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
    endcase

    // Abort overrides every decision above, including a pending done pulse.
    if (abort && state != S_IDLE) begin
      state_nx  = S_IDLE;
      instr_nx  = NOP_WORD;
      valid_nx  = 1'b0;
      busy_nx   = 1'b0;
      done_nx   = 1'b0;
      issued_nx = issued_count;
      bubble_nx = bubble_count;
      sb_shift  = 1'b0;
      sb_clear  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      len_r        <= '0;
      step_r       <= 1'b0;
      cnt          <= '0;
      Instruction  <= NOP_WORD;
      instr_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
      bubble_count <= '0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      len_r        <= len_nx;
      step_r       <= step_nx;
      cnt          <= cnt_nx;
      Instruction  <= instr_nx;
      instr_valid  <= valid_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      issued_count <= issued_nx;
      bubble_count <= bubble_nx;
    end
  end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Bench for instr_issue_sequencer: hazard-mode and fixed-gap instances side by
// side, each checked every cycle against a timestamp-based reference model.
module tb_instr_issue_sequencer;

  localparam int DEPTH   = 16;
  localparam int NOP_GAP = 4;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        resetIn, wrEn, startIn, stepMode, stepIn, abortIn;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  progLen;

  logic [31:0] instr0, instr1;
  logic        valid0, valid1, busy0, busy1, done0, done1;
  logic [15:0] issued0, issued1, bubble0, bubble1;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  // Reference model state, index = hazard mode of the instance.
  logic [31:0] mBuf [2][DEPTH];
  int          readyAt [2][16];
  bit          mActive [2];
  bit          mStepMode [2];
  bit          mNeedStep [2];
  int          mPc [2], mLen [2], mEarliest [2], mStepFrom [2], mDoneAt [2];
  logic [31:0] eInstr [2];
  bit          eValid [2], eBusy [2], eDone [2];
  logic [15:0] eIssued [2], eBubble [2];

  instr_issue_sequencer #(.DEPTH(DEPTH), .NOP_GAP(NOP_GAP), .HAZARD_MODE(0), .NOP_WORD(NOP)) dut0 (
    .clk(clk), .reset(resetIn), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .prog_len(progLen), .start(startIn), .step_mode(stepMode), .step(stepIn), .abort(abortIn),
    .Instruction(instr0), .instr_valid(valid0), .busy(busy0), .done(done0),
    .issued_count(issued0), .bubble_count(bubble0)
  );

  instr_issue_sequencer #(.DEPTH(DEPTH), .NOP_GAP(NOP_GAP), .HAZARD_MODE(1), .NOP_WORD(NOP)) dut1 (
    .clk(clk), .reset(resetIn), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .prog_len(progLen), .start(startIn), .step_mode(stepMode), .step(stepIn), .abort(abortIn),
    .Instruction(instr1), .instr_valid(valid1), .busy(busy1), .done(done1),
    .issued_count(issued1), .bubble_count(bubble1)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit writesReg(input logic [31:0] w);
    if (w[27:26] == 2'b00) return !(w[24:21] >= 4'd8 && w[24:21] <= 4'd11);
    if (w[27:26] == 2'b01) return w[20];
    return 1'b0;
  endfunction

  // A source is usable once its producer is more than NOP_GAP cycles old.
  function automatic bit sourcesReady(input int m, input logic [31:0] w, input int t);
    bit ok = 1'b1;
    if (w[27:26] == 2'b00 || w[27:26] == 2'b01) ok &= (t >= readyAt[m][w[19:16]]);
    if (w[27:26] == 2'b00 && !w[25])            ok &= (t >= readyAt[m][w[3:0]]);
    if (w[27:26] == 2'b01 && !w[20])            ok &= (t >= readyAt[m][w[15:12]]);
    return ok;
  endfunction

  task automatic modelEdge(input int m);
    logic [31:0] w;
    if (wrEn && !eBusy[m]) mBuf[m][wrAddr] = wrData;
    if (resetIn) begin
      eInstr[m] = NOP; eValid[m] = 0; eBusy[m] = 0; eDone[m] = 0;
      eIssued[m] = 0; eBubble[m] = 0; mActive[m] = 0;
      return;
    end
    if (mActive[m] && abortIn) begin
      eInstr[m] = NOP; eValid[m] = 0; eBusy[m] = 0; eDone[m] = 0; mActive[m] = 0;
      return;
    end
    eInstr[m] = NOP; eValid[m] = 0; eDone[m] = 0;
    if (!mActive[m]) begin
      eBusy[m] = 0;
      if (startIn) begin
        eBusy[m] = 1; eIssued[m] = 0; eBubble[m] = 0; mActive[m] = 1;
        mPc[m] = 0; mLen[m] = int'(progLen); mStepMode[m] = stepMode; mNeedStep[m] = 0;
        mEarliest[m] = cyc + 1;
        mDoneAt[m] = (progLen == 0) ? cyc + 1 : -1;
        for (int r = 0; r < 16; r++) readyAt[m][r] = 0;
      end
      return;
    end
    if (cyc == mDoneAt[m]) begin
      eDone[m] = 1; eBusy[m] = 0; mActive[m] = 0;
      return;
    end
    w = mBuf[m][mPc[m] % DEPTH];
    if (mPc[m] < mLen[m] && !mNeedStep[m] && cyc >= mEarliest[m] &&
        (m == 0 || sourcesReady(m, w, cyc))) begin
      eInstr[m] = w; eValid[m] = 1; eIssued[m]++; mPc[m]++;
      if (m == 1 && writesReg(w)) readyAt[m][w[15:12]] = cyc + NOP_GAP + 1;
      if (mPc[m] == mLen[m]) begin
        mDoneAt[m] = cyc + NOP_GAP + 1;
      end else begin
        if (m == 0) mEarliest[m] = cyc + NOP_GAP + 1;
        if (mStepMode[m]) begin
          mNeedStep[m] = 1;
          mStepFrom[m] = (m == 0) ? cyc + NOP_GAP + 1 : cyc + 1;
        end
      end
    end else begin
      eBubble[m]++;
      if (mNeedStep[m] && cyc >= mStepFrom[m] && stepIn) begin
        mNeedStep[m] = 0;
        mEarliest[m] = cyc + 1;
      end
    end
  endtask

  task automatic checkAll();
    for (int m = 0; m < 2; m++) begin
      logic [31:0] gi;
      logic gv, gb, gd;
      logic [15:0] gic, gbc;
      gi  = (m == 1) ? instr1  : instr0;
      gv  = (m == 1) ? valid1  : valid0;
      gb  = (m == 1) ? busy1   : busy0;
      gd  = (m == 1) ? done1   : done0;
      gic = (m == 1) ? issued1 : issued0;
      gbc = (m == 1) ? bubble1 : bubble0;
      checkOutput($sformatf("m%0d_instr@%0d", m, cyc), gi, eInstr[m]);
      checkOutput($sformatf("m%0d_valid@%0d", m, cyc), 32'(gv), 32'(eValid[m]));
      checkOutput($sformatf("m%0d_busy@%0d", m, cyc), 32'(gb), 32'(eBusy[m]));
      checkOutput($sformatf("m%0d_done@%0d", m, cyc), 32'(gd), 32'(eDone[m]));
      checkOutput($sformatf("m%0d_issued@%0d", m, cyc), 32'(gic), 32'(eIssued[m]));
      checkOutput($sformatf("m%0d_bubbles@%0d", m, cyc), 32'(gbc), 32'(eBubble[m]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    cyc++;
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic ab,
                               input logic we, input logic [3:0] wa, input logic [31:0] wd);
    startIn = st; stepIn = sp; abortIn = ab; wrEn = we; wrAddr = wa; wrData = wd;
    tick();
    startIn = 0; stepIn = 0; abortIn = 0; wrEn = 0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 4'd0, 32'd0);
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(0, 0, 0, 1, a, d);
  endtask

  task automatic startRun(input logic [4:0] len, input logic sm);
    progLen = len; stepMode = sm;
    applyStimulus(1, 0, 0, 0, 4'd0, 32'd0);
  endtask

  task automatic runUntilIdle(input int budget, input bit rnd);
    int n = 0;
    while ((mActive[0] || mActive[1]) && n < budget) begin
      if (rnd) begin
        resetIn = ($urandom_range(0, 399) == 0);
        applyStimulus(mActive[0] && mActive[1] && ($urandom_range(0, 15) == 0),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0,
                      $urandom_range(0, 7) == 0, 4'($urandom), $urandom);
        resetIn = 0;
      end else begin
        idleCycle();
      end
      n++;
    end
    checkOutput("run_end", 32'(mActive[0] | mActive[1]), 32'd0);
  endtask

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    w = $urandom;
    w[31:28] = 4'hE;
    w[19:16] = 4'($urandom_range(0, 3));
    w[15:12] = 4'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: begin w[27:25] = 3'b000; w[3:0] = 4'($urandom_range(0, 3)); end
      1: w[27:25] = 3'b001;
      2: w[27:26] = 2'b01;
      default: w[27:26] = 2'b10;
    endcase
    return w;
  endfunction

  initial begin
    resetIn = 1; wrEn = 0; startIn = 0; stepMode = 0; stepIn = 0; abortIn = 0;
    wrAddr = 0; wrData = 0; progLen = 0;
    for (int m = 0; m < 2; m++) begin
      eBusy[m] = 0; mActive[m] = 0;
      for (int a = 0; a < DEPTH; a++) mBuf[m][a] = 32'd0;
    end
    tick();
    tick();
    resetIn = 0;
    for (int a = 0; a < DEPTH; a++) writeWord(4'(a), randWord());

    // Dependent pair: one bubble gap of NOP_GAP in both modes.
    writeWord(4'd0, 32'hE2900007);
    writeWord(4'd1, 32'hE2901002);
    startRun(5'd2, 1'b0);
    runUntilIdle(100, 0);
    checkOutput("t1_issued_m1", 32'(issued1), 32'd2);
    checkOutput("t1_bubbles_m1", 32'(bubble1), 32'd8);
    checkOutput("t1_bubbles_m0", 32'(bubble0), 32'd8);

    // Independent words: back-to-back with hazard detection, gapped otherwise.
    writeWord(4'd1, 32'hE2832001);
    writeWord(4'd2, 32'hE2844001);
    startRun(5'd3, 1'b0);
    runUntilIdle(100, 0);
    checkOutput("t2_issued_m1", 32'(issued1), 32'd3);
    checkOutput("t2_bubbles_m1", 32'(bubble1), 32'd4);
    checkOutput("t3_issued_m0", 32'(issued0), 32'd3);
    checkOutput("t3_bubbles_m0", 32'(bubble0), 32'd12);

    // Single-step: nothing advances until the step pulse.
    writeWord(4'd1, 32'hE2901002);
    startRun(5'd2, 1'b1);
    for (int i = 0; i < 12; i++) idleCycle();
    checkOutput("t4_held_m1", 32'(issued1), 32'd1);
    checkOutput("t4_held_m0", 32'(issued0), 32'd1);
    applyStimulus(0, 1, 0, 0, 4'd0, 32'd0);
    runUntilIdle(100, 0);
    checkOutput("t4_after_step_m1", 32'(issued1), 32'd2);

    // Abort mid-run, write while busy, zero-length run.
    startRun(5'd2, 1'b0);
    idleCycle();
    idleCycle();
    applyStimulus(0, 0, 1, 0, 4'd0, 32'd0);
    checkOutput("t5_abort_busy", 32'(busy1), 32'd0);
    checkOutput("t5_abort_issued", 32'(issued1), 32'd1);
    for (int i = 0; i < 8; i++) begin
      idleCycle();
      checkOutput("t5_no_done", 32'(done1), 32'd0);
    end
    startRun(5'd2, 1'b0);
    writeWord(4'd0, 32'hE3A01005);
    runUntilIdle(100, 0);
    startRun(5'd1, 1'b0);
    idleCycle();
    checkOutput("t5_old_word", instr1, 32'hE2900007);
    runUntilIdle(100, 0);
    startRun(5'd0, 1'b0);
    idleCycle();
    checkOutput("t5_len0_done", 32'(done1), 32'd1);

    // Reset in the middle of a run, then a clean rerun.
    startRun(5'd2, 1'b0);
    idleCycle();
    idleCycle();
    resetIn = 1;
    idleCycle();
    resetIn = 0;
    checkOutput("t6_instr", instr1, NOP);
    checkOutput("t6_busy", 32'(busy1), 32'd0);
    checkOutput("t6_bubbles", 32'(bubble1), 32'd0);
    startRun(5'd2, 1'b0);
    runUntilIdle(100, 0);
    checkOutput("t6_rerun_issued", 32'(issued1), 32'd2);
    checkOutput("t6_rerun_bubbles", 32'(bubble1), 32'd8);

    // Randomized programs, lengths, step pulses, aborts and stray writes.
    for (int run = 0; run < 40; run++) begin
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) writeWord(4'($urandom), randWord());
      startRun(5'($urandom_range(0, DEPTH)), 1'($urandom_range(0, 2) == 0));
      runUntilIdle(600, 1);
      idleCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
